// File: rtl/serial_half_subtractor.sv
// Bit-serial unsigned subtractor: diff = a - b, LSB first, one bit per clock,
// with a registered borrow and a start/busy/done handshake.
module serial_half_subtractor #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] diff,
  output logic             borrow
);

  // Handshake: start is a request honoured only in IDLE; a/b are captured on
  // that edge. busy is high for the WIDTH cycles of RUN; done is a one-cycle
  // pulse during which diff/borrow are valid, and they hold until the next start.

  localparam int CW = $clog2(WIDTH) + 1;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  // Observable FSM state for checkers bound to this block.
  state_t           state;
  logic [WIDTH-1:0] a_sh;
  logic [WIDTH-1:0] b_sh;
  logic [WIDTH-1:0] res;
  logic             bw;
  logic [CW-1:0]    cnt;

  logic             d;
  logic             bw_next;
  logic [WIDTH-1:0] res_next;

  // Full-subtractor cell on the current LSBs and the stored borrow.
  always_comb begin
    d        = a_sh[0] ^ b_sh[0] ^ bw;
    bw_next  = (~a_sh[0] & b_sh[0]) | (~(a_sh[0] ^ b_sh[0]) & bw);
    res_next = {d, res[WIDTH-1:1]};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= S_IDLE;
      a_sh   <= '0;
      b_sh   <= '0;
      res    <= '0;
      bw     <= 1'b0;
      cnt    <= '0;
      diff   <= '0;
      borrow <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (start) begin
            a_sh  <= a;
            b_sh  <= b;
            bw    <= 1'b0;
            cnt   <= '0;
            res   <= '0;
            state <= S_RUN;
          end
        end
        S_RUN: begin
          res  <= res_next;
          bw   <= bw_next;
          a_sh <= a_sh >> 1;
          b_sh <= b_sh >> 1;
          cnt  <= cnt + 1'b1;
          if (cnt == CW'(WIDTH - 1)) begin
            diff   <= res_next;
            borrow <= bw_next;
            state  <= S_DONE;
          end
        end
        S_DONE: begin
          state <= S_IDLE;
        end
        default: begin
          state <= S_IDLE;
        end
      endcase
    end
  end

  // Both flags are decoded straight from the state flop, so they never glitch
  // and can never be high together.
  assign busy = (state == S_RUN);
  assign done = (state == S_DONE);

endmodule
